// File: rtl/ctrl_host.sv
// Host-side UART link: sends a tx_data command as 8N1 bytes, then collects an RX_WIDTH response.
// Latency: start bit from the cycle after start; done on the cycle the last stop bit is sampled.
// No backpressure: start is ignored while busy. Optional receive timeout: CTRL_HOST_TIMEOUT_EN.
module ctrl_host #(
    parameter int FREQ     = 28125000,
    parameter int BAUD     = 115200,
    parameter int TX_WIDTH = 32,
    parameter int RX_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [TX_WIDTH-1:0] tx_data,
    output logic                busy,
    output logic                done,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                err,
    output logic                uart_tx,
    input  logic                uart_rx
);

    localparam int DIV  = FREQ / BAUD;
    localparam int NTX  = (TX_WIDTH + 7) / 8;
    localparam int NRX  = (RX_WIDTH + 7) / 8;
    localparam int TXB  = NTX * 8;
    localparam int RXB  = NRX * 8;
    localparam int CW   = $clog2(DIV + 1);
    localparam int NTXW = $clog2(NTX + 1);
    localparam int NRXW = $clog2(NRX + 1);

    localparam logic [CW-1:0]   DIV_C   = CW'(DIV);
    localparam logic [CW-1:0]   DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF_C  = CW'(DIV / 2);
    localparam logic [NTXW-1:0] LAST_TX = NTXW'(NTX - 1);
    localparam logic [NRXW-1:0] LAST_RX = NRXW'(NRX - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX} state_t;
    state_t state;

    logic [TXB-1:0]  tx_sr;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;
    logic [NTXW-1:0] tx_byte;

    logic            rx_s1, rx_s2, rx_prev;
    logic            rx_active;
    logic [CW-1:0]   rx_cnt;
    logic [3:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic [RXB-1:0]  rx_sr;
    logic [NRXW-1:0] rx_count;

    logic            rx_edge, rx_tick, rx_stop, rx_keep, rx_last, timeout;
    logic [RXB-1:0]  rx_next;

    // rx_bit 0 is the start bit (sampled half a bit in), 1..8 data, 9 stop.
    assign rx_edge = rx_prev & ~rx_s2 & ~rx_active;
    assign rx_tick = rx_active && (rx_cnt == ((rx_bit == 4'd0) ? HALF_C : DIV_C));
    assign rx_stop = rx_tick && (rx_bit == 4'd9);
    assign rx_keep = rx_stop && (state != IDLE);
    assign rx_last = rx_keep && (rx_count == LAST_RX);
    assign rx_next = (rx_sr >> 8) | (RXB'(rx_shift) << (RXB - 8));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_edge) begin
                rx_active <= 1'b1;
                rx_cnt    <= CW'(1);
                rx_bit    <= '0;
            end else if (rx_active) begin
                if (rx_tick) begin
                    rx_cnt <= CW'(1);
                    if ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9) begin
                        rx_active <= 1'b0;
                    end else begin
                        rx_bit <= rx_bit + 4'd1;
                        if (rx_bit != 4'd0)
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                    end
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            end
        end
    end

`ifdef CTRL_HOST_TIMEOUT_EN
    localparam int TO_LIM = 64 * 10 * DIV;
    localparam int TOW    = $clog2(TO_LIM + 1);
    logic [TOW-1:0] to_cnt;

    // Restarts on every start edge and stays clear while a character is in flight.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT_RX || rx_active || rx_edge)
            to_cnt <= '0;
        else if (!timeout)
            to_cnt <= to_cnt + TOW'(1);
    end
    assign timeout = (to_cnt == TOW'(TO_LIM - 1)) && !rx_edge;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rx_data  <= '0;
            uart_tx  <= 1'b1;
            tx_sr    <= '0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            rx_sr    <= '0;
            rx_count <= '0;
        end else begin
            done <= 1'b0;
            if (done) begin
                state   <= IDLE;
                busy    <= 1'b0;
                uart_tx <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= SEND;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            uart_tx  <= 1'b0;
                            tx_sr    <= TXB'(tx_data);
                            tx_cnt   <= '0;
                            tx_bit   <= '0;
                            tx_byte  <= '0;
                            rx_sr    <= '0;
                            rx_count <= '0;
                        end
                    end
                    SEND: begin
                        if (tx_cnt == DIV_M1) begin
                            tx_cnt <= '0;
                            if (tx_bit == 4'd9) begin
                                if (tx_byte == LAST_TX) begin
                                    state   <= WAIT_RX;
                                    uart_tx <= 1'b1;
                                end else begin
                                    tx_byte <= tx_byte + NTXW'(1);
                                    tx_bit  <= '0;
                                    uart_tx <= 1'b0;
                                end
                            end else begin
                                tx_bit <= tx_bit + 4'd1;
                                if (tx_bit == 4'd8) begin
                                    uart_tx <= 1'b1;
                                end else begin
                                    uart_tx <= tx_sr[0];
                                    tx_sr   <= tx_sr >> 1;
                                end
                            end
                        end else begin
                            tx_cnt <= tx_cnt + CW'(1);
                        end
                    end
                    WAIT_RX: begin
                        if (timeout) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // A bad stop bit still yields a stored, counted byte.
            if (rx_keep) begin
                rx_sr    <= rx_next;
                rx_count <= rx_count + NRXW'(1);
                if (!rx_s2)
                    err <= 1'b1;
                if (rx_last) begin
                    rx_data <= rx_next[RX_WIDTH-1:0];
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ctrl_host.md
CTRL_HOST -- requirements
Module: ctrl_host

Interface
REQ-001 Parameter FREQ, default 28125000, clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; bit period DIV = FREQ/BAUD, integer-truncated.
REQ-003 Parameter TX_WIDTH, default 32, width of the command vector sent to the remote control unit.
REQ-004 Parameter RX_WIDTH, default 32, width of the response vector returned by the remote control unit.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request one transaction; sampled only when busy=0.
REQ-008 tx_data  input  TX_WIDTH  command vector, captured on accepted start.
REQ-009 busy  output  1  transaction in progress.
REQ-010 done  output  1  one-cycle pulse: response complete.
REQ-011 rx_data  output  RX_WIDTH  last complete response, held until the next done.
REQ-012 err  output  1  sticky error flag (framing or timeout), cleared on accepted start.
REQ-013 uart_tx  output  1  serial line to the remote control unit, idle high.
REQ-014 uart_rx  input  1  serial line from the remote control unit, asynchronous.

Function
REQ-015 Framing SHALL be 8N1: one start bit (0), 8 data bits LSB-first, one stop bit (1), each DIV cycles.
REQ-016 Transaction: send NTX = ceil(TX_WIDTH/8) bytes of tx_data, least significant byte first, unused MSBs zero-padded; then receive NRX = ceil(RX_WIDTH/8) bytes, least significant first.
REQ-017 State machine: IDLE -> SEND on start && !busy; SEND -> WAIT_RX after the last stop bit completes; WAIT_RX -> IDLE after the NRX-th byte (done=1) or on abort.
REQ-018 start accepted in cycle N: busy=1 and uart_tx=0 (start bit) from cycle N+1; consecutive bytes back-to-back, no idle gap.
REQ-019 start asserted while busy=1 SHALL be ignored; tx_data changes after acceptance have no effect.
REQ-020 uart_rx SHALL pass through a 2-flop synchronizer before use.
REQ-021 Receiver detects the start edge as a high-to-low transition, samples at DIV/2 after it; a start bit no longer low at that point is discarded as a glitch.
REQ-022 Data and stop bits sampled every DIV cycles after the start-bit centre.
REQ-023 A stop bit sampled 0 SHALL set err; the byte is still stored and counted.
REQ-024 The receiver runs in SEND as well; bytes completing outside WAIT_RX or SEND SHALL be discarded.
REQ-025 On the cycle the NRX-th stop bit is sampled: rx_data updated (excess received bits above RX_WIDTH dropped), done=1 for one cycle, busy=0 the following cycle.
REQ-026 A new start is accepted in the same cycle busy first reads 0.

Reset
REQ-027 reset SHALL force in the next cycle: uart_tx=1, busy=0, done=0, err=0, rx_data=0, state IDLE, all counters zero.
REQ-028 reset mid-character SHALL abandon the transaction; uart_tx returns high immediately, no done pulse.

Configuration
REQ-029 Macro CTRL_HOST_TIMEOUT_EN: when defined, WAIT_RX aborts if no start edge is detected within 64*10*DIV cycles of entering WAIT_RX or of the last received stop bit; abort sets err=1, returns to IDLE, no done, rx_data unchanged.
REQ-030 Without CTRL_HOST_TIMEOUT_EN, WAIT_RX waits indefinitely and err is set only by framing errors.

Verification (FREQ=16, BAUD=1, DIV=16)
REQ-031 TX_WIDTH=12, tx_data=0xABC, start one cycle -> uart_tx carries 0xBC then 0x0A, 160 cycles each, start bit begins cycle after start.
REQ-032 RX_WIDTH=16, bench replies 0x34 then 0x12 -> single done pulse, rx_data=0x1234, busy drops one cycle after done.
REQ-033 Bench replies 0x55 with stop bit 0 -> err=1, byte stored; err clears on the next accepted start.
REQ-034 With CTRL_HOST_TIMEOUT_EN, no reply -> err=1, busy=0 after 10240 cycles in WAIT_RX, no done; without it, busy stays 1.
REQ-035 reset asserted during the 5th data bit of the first byte -> next cycle uart_tx=1, busy=0; new start then sends a complete frame.
REQ-036 start pulsed while busy=1 and 8-cycle low glitch on uart_rx -> both ignored, transaction and response unaffected.
